// File: rtl/bitslip_aligner.sv
// Multi-channel word aligner: each channel slips its deserialized word until it
// sees TRAIN for MATCH_CNT consecutive checks, or gives up after DATAWIDTH slips.
module bitslip_aligner #(
    parameter int                   NCH        = 4,
    parameter int                   DATAWIDTH  = 10,
    parameter logic [DATAWIDTH-1:0] TRAIN      = 10'h3A6,
    parameter int                   SETTLE_CYC = 4,
    parameter int                   MATCH_CNT  = 16,
    localparam int                  SW         = (DATAWIDTH <= 2) ? 1 : $clog2(DATAWIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     align_start,
    input  logic [NCH-1:0]           bitslip,
    input  logic [NCH*DATAWIDTH-1:0] din,
    output logic [NCH*DATAWIDTH-1:0] dout,
    output logic [NCH*SW-1:0]        slip_pos,
    output logic [NCH-1:0]           aligned,
    output logic [NCH-1:0]           fail,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    state_e               state_q   [NCH];
    state_e               state_d   [NCH];
    logic [DATAWIDTH-1:0] last_q    [NCH];
    logic [DATAWIDTH-1:0] last_d    [NCH];
    logic [DATAWIDTH-1:0] dout_q    [NCH];
    logic [DATAWIDTH-1:0] dout_d    [NCH];
    logic [SW-1:0]        s_q       [NCH];
    logic [SW-1:0]        s_d       [NCH];
    logic [7:0]           settle_q  [NCH];
    logic [7:0]           settle_d  [NCH];
    logic [7:0]           match_q   [NCH];
    logic [7:0]           match_d   [NCH];
    logic [4:0]           attempt_q [NCH];
    logic [4:0]           attempt_d [NCH];
    logic [NCH-1:0]       aligned_q;
    logic [NCH-1:0]       aligned_d;
    logic [NCH-1:0]       fail_q;
    logic [NCH-1:0]       fail_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;

    // Window of {prev, cur} whose MSB sits s bits below the MSB of prev.
    function automatic logic [DATAWIDTH-1:0] slip_window(
        input logic [DATAWIDTH-1:0] prev,
        input logic [DATAWIDTH-1:0] cur,
        input logic [SW-1:0]        s
    );
        logic [2*DATAWIDTH-1:0] cat;
        cat = {prev, cur} << s;
        return cat[2*DATAWIDTH-1 -: DATAWIDTH];
    endfunction

    function automatic logic [SW-1:0] slip_inc(input logic [SW-1:0] s);
        return (s == SW'(DATAWIDTH - 1)) ? {SW{1'b0}} : s + SW'(1);
    endfunction

    // Per-channel datapath and training state machine next-state logic.
    always_comb begin
        busy_d = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            last_d[c]    = din[c*DATAWIDTH +: DATAWIDTH];
            dout_d[c]    = slip_window(last_q[c], din[c*DATAWIDTH +: DATAWIDTH], s_q[c]);
            state_d[c]   = state_q[c];
            s_d[c]       = s_q[c];
            settle_d[c]  = settle_q[c];
            match_d[c]   = match_q[c];
            attempt_d[c] = attempt_q[c];
            if (align_start) begin
                state_d[c]   = ST_SETTLE;
                settle_d[c]  = 8'(SETTLE_CYC);
                attempt_d[c] = 5'd0;
            end else begin
                case (state_q[c])
                    ST_IDLE, ST_LOCKED, ST_FAIL: begin
                        if (bitslip[c]) begin
                            s_d[c]     = slip_inc(s_q[c]);
                            state_d[c] = ST_IDLE;
                        end else begin
                            state_d[c] = state_q[c];
                        end
                    end
                    ST_SETTLE: begin
                        settle_d[c] = settle_q[c] - 8'd1;
                        if (settle_d[c] == 8'd0) begin
                            state_d[c] = ST_CHECK;
                            match_d[c] = 8'd0;
                        end else begin
                            state_d[c] = ST_SETTLE;
                        end
                    end
                    ST_CHECK: begin
                        if (dout_q[c] == TRAIN) begin
                            match_d[c] = match_q[c] + 8'd1;
                            if (match_d[c] == 8'(MATCH_CNT)) begin
                                state_d[c] = ST_LOCKED;
                            end else begin
                                state_d[c] = ST_CHECK;
                            end
                        end else begin
                            // A full lap of slips without a lock returns s to its start.
                            s_d[c]       = slip_inc(s_q[c]);
                            attempt_d[c] = attempt_q[c] + 5'd1;
                            if (attempt_d[c] == 5'(DATAWIDTH)) begin
                                state_d[c] = ST_FAIL;
                            end else begin
                                state_d[c]  = ST_SETTLE;
                                settle_d[c] = 8'(SETTLE_CYC);
                            end
                        end
                    end
                    default: state_d[c] = ST_IDLE;
                endcase
            end
            aligned_d[c] = (state_d[c] == ST_LOCKED);
            fail_d[c]    = (state_d[c] == ST_FAIL);
            busy_d       = busy_d | (state_d[c] == ST_SETTLE) | (state_d[c] == ST_CHECK);
        end
        done_d = busy_q & ~busy_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]   <= ST_IDLE;
                last_q[c]    <= {DATAWIDTH{1'b0}};
                dout_q[c]    <= {DATAWIDTH{1'b0}};
                s_q[c]       <= {SW{1'b0}};
                settle_q[c]  <= 8'd0;
                match_q[c]   <= 8'd0;
                attempt_q[c] <= 5'd0;
            end
            aligned_q <= {NCH{1'b0}};
            fail_q    <= {NCH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]   <= state_d[c];
                last_q[c]    <= last_d[c];
                dout_q[c]    <= dout_d[c];
                s_q[c]       <= s_d[c];
                settle_q[c]  <= settle_d[c];
                match_q[c]   <= match_d[c];
                attempt_q[c] <= attempt_d[c];
            end
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Pack per-channel registers onto the flat output buses.
    always_comb begin
        dout     = {(NCH*DATAWIDTH){1'b0}};
        slip_pos = {(NCH*SW){1'b0}};
        for (int c = 0; c < NCH; c++) begin
            dout[c*DATAWIDTH +: DATAWIDTH] = dout_q[c];
            slip_pos[c*SW +: SW]           = s_q[c];
        end
    end

    assign aligned = aligned_q;
    assign fail    = fail_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bitslip_aligner.sv
// Directed bench for bitslip_aligner with NCH=2, DATAWIDTH=10.
module tb_bitslip_aligner;

    localparam int          NCH = 2;
    localparam int          DW  = 10;
    localparam int          SW  = 4;
    localparam logic [9:0]  T   = 10'h3A6;

    logic              clk = 1'b0;
    logic              reset;
    logic              align_start;
    logic [NCH-1:0]    bitslip;
    logic [NCH*DW-1:0] din;
    logic [NCH*DW-1:0] dout;
    logic [NCH*SW-1:0] slip_pos;
    logic [NCH-1:0]    aligned;
    logic [NCH-1:0]    fail;
    logic              busy;
    logic              done;

    int nvec = 0;
    int nerr = 0;
    int dcnt, dcyc, a0cyc, a1cyc, busy_seen;

    bitslip_aligner #(
        .NCH(NCH), .DATAWIDTH(DW), .TRAIN(T), .SETTLE_CYC(4), .MATCH_CNT(16)
    ) dut (
        .clk(clk), .reset(reset), .align_start(align_start), .bitslip(bitslip),
        .din(din), .dout(dout), .slip_pos(slip_pos), .aligned(aligned),
        .fail(fail), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] rotr(input logic [9:0] x, input int n);
        logic [19:0] w;
        w = {x, x} >> n;
        return w[9:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cnt, output int cyc);
        cnt = 0;
        cyc = -1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (done) begin
                cnt++;
                if (cyc < 0) cyc = i + 1;
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        align_start = 1'b0;
        bitslip     = 2'b00;
        din         = {T, T};
        tick();
        tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_slip", 32'(slip_pos), 32'h0);
        chk("rst_flags", {28'h0, aligned, fail}, 32'h0);
        chk("rst_busy_done", {30'h0, busy, done}, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("pass_thru_s0", 32'(dout), 32'({T, T}));

        // All channels already aligned.
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'h1);
        wait_done(30, dcnt, dcyc);
        chk("a037_done_count", 32'(dcnt), 32'h1);
        chk("a037_done_in_window", 32'((dcyc >= 20) && (dcyc <= 22)), 32'h1);
        chk("a037_aligned", 32'(aligned), 32'h3);
        chk("a037_slip", 32'(slip_pos), 32'h00);
        chk("a037_busy_low", 32'(busy), 32'h0);

        // Channels needing different slip counts.
        din = {rotr(T, 7), rotr(T, 3)};
        tick();
        tick();
        pulse_start();
        dcnt = 0; dcyc = -1; a0cyc = -1; a1cyc = -1;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (aligned[0] && a0cyc < 0) a0cyc = i;
            if (aligned[1] && a1cyc < 0) a1cyc = i;
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = i;
            end
        end
        chk("a038_slip", 32'(slip_pos), 32'h73);
        chk("a038_aligned", 32'(aligned), 32'h3);
        chk("a038_done_count", 32'(dcnt), 32'h1);
        chk("a038_ch0_first", 32'((a0cyc >= 0) && (a0cyc < a1cyc)), 32'h1);
        chk("a038_done_with_ch1", 32'(dcyc), 32'(a1cyc));
        chk("a038_dout", 32'(dout), 32'({T, T}));

        // Manual slips out of LOCKED, then retrain at s=5.
        din = {rotr(T, 7), rotr(T, 5)};
        bitslip = 2'b01;
        tick();
        bitslip = 2'b00;
        chk("slip_from_locked_aligned", 32'(aligned), 32'h2);
        chk("slip_from_locked_pos", 32'(slip_pos), 32'h74);
        bitslip = 2'b01;
        tick();
        bitslip = 2'b00;
        pulse_start();
        wait_done(40, dcnt, dcyc);
        chk("relock_s5_slip", 32'(slip_pos), 32'h75);
        chk("relock_s5_aligned", 32'(aligned), 32'h3);
        bitslip     = 2'b01;
        align_start = 1'b1;
        tick();
        bitslip     = 2'b00;
        align_start = 1'b0;
        chk("start_beats_slip_pos", 32'(slip_pos), 32'h75);
        chk("start_beats_slip_busy", {30'h0, busy, aligned[0]}, 32'h2);
        wait_done(40, dcnt, dcyc);
        chk("start_beats_slip_relock", 32'(aligned), 32'h3);

        // Untrainable input: full lap of slips then FAIL; slips during SETTLE ignored.
        din = {10'h000, 10'h000};
        tick();
        tick();
        pulse_start();
        tick();
        bitslip = 2'b11;
        tick();
        bitslip = 2'b00;
        wait_done(100, dcnt, dcyc);
        chk("a039_fail", 32'(fail), 32'h3);
        chk("a039_aligned", 32'(aligned), 32'h0);
        chk("a039_slip_restored", 32'(slip_pos), 32'h75);
        chk("a039_done_count", 32'(dcnt), 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("fail_persists", 32'(fail), 32'h3);
        bitslip = 2'b10;
        tick();
        bitslip = 2'b00;
        chk("slip_from_fail_flags", 32'(fail), 32'h1);
        chk("slip_from_fail_pos", 32'(slip_pos), 32'h85);

        // Manual slip wrap in IDLE after a reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("reset_clears_slip", 32'(slip_pos), 32'h00);
        bitslip = 2'b01;
        for (int i = 0; i < 12; i++) tick();
        bitslip = 2'b00;
        tick();
        chk("a040_wrap", 32'(slip_pos), 32'h02);
        chk("a040_idle", {29'h0, busy, aligned}, 32'h0);

        // Reset mid-CHECK.
        din = {T, T};
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        chk("a042_busy_before", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("a042_dout_async", 32'(dout), 32'h0);
        chk("a042_slip_async", 32'(slip_pos), 32'h0);
        chk("a042_flags_async", {26'h0, aligned, fail, busy, done}, 32'h0);
        dcnt = 0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dcnt++;
        end
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) dcnt++;
            if (busy || aligned != 2'b00) busy_seen++;
        end
        chk("a042_no_done", 32'(dcnt), 32'h0);
        chk("a042_stays_idle", 32'(busy_seen), 32'h0);
        chk("a042_slip_after", 32'(slip_pos), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bitslip_aligner.md
BITSLIP_ALIGNER -- requirements
Module: bitslip_aligner

Interface
REQ-001 Parameter NCH, default 4, number of independent channels (1..16).
REQ-002 Parameter DATAWIDTH, default 10, bits per channel word (2..16).
REQ-003 Parameter TRAIN, default 10'h3A6, training word each channel aligns to (DATAWIDTH bits).
REQ-004 Parameter SETTLE_CYC, default 4, wait cycles after each slip before checking (1..255).
REQ-005 Parameter MATCH_CNT, default 16, consecutive matches required for lock (1..255).
REQ-006 SW denotes max(1, clog2(DATAWIDTH)).
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 align_start  in  1  one-cycle pulse; (re)starts training on all channels.
REQ-010 bitslip  in  NCH  per-channel manual slip pulse.
REQ-011 din  in  NCH*DATAWIDTH  deserialized words; channel c at bits [c*DATAWIDTH +: DATAWIDTH].
REQ-012 dout  out  NCH*DATAWIDTH  realigned words, same packing.
REQ-013 slip_pos  out  NCH*SW  current slip index per channel.
REQ-014 aligned  out  NCH  channel in LOCKED.
REQ-015 fail  out  NCH  channel in FAIL.
REQ-016 busy  out  1  any channel in SETTLE or CHECK.
REQ-017 done  out  1  one-cycle pulse when busy falls.

Function
REQ-018 Per channel, last register SHALL capture din every cycle.
REQ-019 With slip index s, dout SHALL be registered as the DATAWIDTH bits of {last, din} starting s bits below the MSB of last; s=0 gives last.
REQ-020 Latency din->dout SHALL be 2 cycles; a constant word x SHALL appear on dout rotated left by s.
REQ-021 s SHALL increment modulo DATAWIDTH (DATAWIDTH-1 -> 0); new s affects dout on the next cycle.
REQ-022 Per-channel FSM states: IDLE, SETTLE, CHECK, LOCKED, FAIL.
REQ-023 align_start in any state -> SETTLE; settle counter=SETTLE_CYC, attempt counter=0, s unchanged; clears aligned and fail.
REQ-024 SETTLE: decrement each cycle; on reaching 0 -> CHECK with match counter=0.
REQ-025 CHECK, dout==TRAIN: match counter+1; reaching MATCH_CNT -> LOCKED.
REQ-026 CHECK, dout!=TRAIN: s+1, attempt+1; attempt reaching DATAWIDTH -> FAIL, else -> SETTLE with counter reloaded.
REQ-027 On FAIL, s SHALL therefore equal its value at align_start (DATAWIDTH slips total).
REQ-028 Manual bitslip[c] SHALL increment s only in IDLE, LOCKED or FAIL; ignored in SETTLE/CHECK.
REQ-029 Manual bitslip in LOCKED or FAIL -> IDLE, clearing aligned/fail.
REQ-030 align_start and bitslip in the same cycle: align_start wins; bitslip ignored.
REQ-031 LOCKED and FAIL SHALL persist until align_start, bitslip or reset.
REQ-032 busy registered; done asserts exactly one cycle, the cycle after busy goes 1->0.
REQ-033 align_start while busy restarts all channels; no done pulse for the aborted run.
REQ-034 Channels SHALL align independently; done waits for the slowest channel.

Reset
REQ-035 reset low SHALL immediately force: dout=0, last=0, s=0, counters=0, aligned=0, fail=0, busy=0, done=0, all FSMs IDLE.
REQ-036 Reset low mid-training SHALL abort with no done pulse; after release, blocks stay IDLE until align_start.

Verification
REQ-037 NCH=2, all din=10'h3A6, align_start -> busy 1 cycle later; aligned=2'b11, slip_pos=0/0; done one pulse within 2+SETTLE_CYC+MATCH_CNT cycles.
REQ-038 ch0 din=rotr(10'h3A6,3), ch1 din=rotr(10'h3A6,7), align_start -> slip_pos ch0=3, ch1=7; both aligned; single done after ch1 locks.
REQ-039 din=10'h000 constant, align_start -> fail=1, aligned=0 after 10 attempts; slip_pos back at start value; done pulses once.
REQ-040 IDLE, 12 bitslip[0] pulses with DATAWIDTH=10 -> slip_pos ch0=2 (wrap at 10); other channels 0.
REQ-041 bitslip[0] and align_start same cycle while ch0 LOCKED at s=5 -> s stays 5, ch0 re-enters SETTLE.
REQ-042 reset low during CHECK -> all outputs 0 same cycle (before next clk edge); no done; after release state IDLE, slip_pos=0.
